// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction-memory loader: state encoding and
// default memory geometry.
package riscv_pkg;

   // Default instruction memory size in 32-bit words and its word-address width.
   localparam int IMEM_DEPTH  = 1024;
   localparam int IMEM_ADDR_W = 10;

   // Program loader FSM states.
   typedef enum logic [2:0] {
      LDR_IDLE   = 3'd0,
      LDR_LOAD   = 3'd1,
      LDR_COMMIT = 3'd2,
      LDR_DONE   = 3'd3,
      LDR_ERROR  = 3'd4
   } ldr_state_e;

endpackage : riscv_pkg

// File: rtl/imem_loader.sv
// Instruction memory loader: streams a program from a valid/ready source into
// IMEM. The core is held in reset until the last word has been written.
// Each accepted beat becomes exactly one registered write on the following
// cycle. A program longer than DEPTH words ends in ERROR with overflow set.
module imem_loader
   import riscv_pkg::*;
#(
   parameter int DEPTH  = IMEM_DEPTH,
   parameter int ADDR_W = IMEM_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [31:0]       in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wd,
   output logic              cpu_rst,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W:0]   word_count
);

   // Index of the final IMEM word; a non-last beat here overflows the memory.
   localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);
   localparam logic [ADDR_W:0] WC_ONE   = (ADDR_W+1)'(1);

   ldr_state_e        state_q, state_d;
   logic [ADDR_W:0]   word_count_q, word_count_d;
   logic              overflow_q, overflow_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wd_q, mem_wd_d;
   logic              cpu_rst_q, cpu_rst_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              accept_s;

   // Ready is a pure decode of the current state so the source sees it early.
   assign in_ready = (state_q == LDR_LOAD);
   assign accept_s = in_valid && in_ready;

   // Next-state, write-issue and status computation.
   always_comb begin
      state_d      = state_q;
      word_count_d = word_count_q;
      overflow_d   = overflow_q;
      mem_we_d     = 1'b0;
      mem_addr_d   = mem_addr_q;
      mem_wd_d     = mem_wd_q;
      case (state_q)
         LDR_IDLE, LDR_DONE, LDR_ERROR: begin
            if (start) begin
               state_d      = LDR_LOAD;
               word_count_d = '0;
               overflow_d   = 1'b0;
            end else begin
               state_d = state_q;
            end
         end
         LDR_LOAD: begin
            if (accept_s) begin
               mem_we_d     = 1'b1;
               mem_addr_d   = word_count_q[ADDR_W-1:0];
               mem_wd_d     = in_data;
               word_count_d = word_count_q + WC_ONE;
               if (in_last) begin
                  state_d = LDR_COMMIT;
               end else if (word_count_q == LAST_IDX) begin
                  state_d    = LDR_ERROR;
                  overflow_d = 1'b1;
               end else begin
                  state_d = LDR_LOAD;
               end
            end else begin
               state_d = LDR_LOAD;
            end
         end
         LDR_COMMIT: begin
            state_d = LDR_DONE;
         end
         default: begin
            state_d = LDR_IDLE;
         end
      endcase
      cpu_rst_d = (state_d != LDR_DONE);
      busy_d    = (state_d == LDR_LOAD) || (state_d == LDR_COMMIT);
      done_d    = (state_d == LDR_DONE);
   end

   // State and registered outputs; reset also drops any write still pending.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= LDR_IDLE;
         word_count_q <= '0;
         overflow_q   <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wd_q     <= 32'h0000_0000;
         cpu_rst_q    <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         word_count_q <= word_count_d;
         overflow_q   <= overflow_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wd_q     <= mem_wd_d;
         cpu_rst_q    <= cpu_rst_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wd     = mem_wd_q;
   assign cpu_rst    = cpu_rst_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign overflow   = overflow_q;
   assign word_count = word_count_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader (DEPTH=1024).
module tb_imem_loader;

   localparam int DEPTH  = 1024;
   localparam int ADDR_W = 10;

   logic              clk;
   logic              rst;
   logic              start;
   logic              in_valid;
   logic [31:0]       in_data;
   logic              in_last;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wd;
   logic              cpu_rst;
   logic              busy;
   logic              done;
   logic              overflow;
   logic [ADDR_W:0]   word_count;

   int n_checks = 0;
   int n_fails  = 0;

   // Write log filled by the monitor.
   logic [ADDR_W-1:0] log_addr [0:4095];
   logic [31:0]       log_data [0:4095];
   int                wr_n = 0;

   imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_last    (in_last),
      .in_ready   (in_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wd     (mem_wd),
      .cpu_rst    (cpu_rst),
      .busy       (busy),
      .done       (done),
      .overflow   (overflow),
      .word_count (word_count)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Record every IMEM write mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         if (wr_n < 4096) begin
            log_addr[wr_n] = mem_addr;
            log_data[wr_n] = mem_wd;
         end
         wr_n = wr_n + 1;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks = n_checks + 1;
      if (got !== exp) begin
         n_fails = n_fails + 1;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Present one beat for one cycle (always accepted while in LOAD).
   task automatic beat(input logic [31:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   logic [31:0] prog [0:3];
   int          base;
   int          bad;

   initial begin
      prog[0] = 32'h0050_0093;
      prog[1] = 32'h0010_8113;
      prog[2] = 32'h0020_81B3;
      prog[3] = 32'h0000_006F;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 32'h0; in_last = 1'b0;
      step(); step();
      rst = 1'b0;

      // Reset state
      check("rst_cpu_rst",  {63'd0, cpu_rst},  64'd1);
      check("rst_busy",     {63'd0, busy},     64'd0);
      check("rst_done",     {63'd0, done},     64'd0);
      check("rst_overflow", {63'd0, overflow}, 64'd0);
      check("rst_mem_we",   {63'd0, mem_we},   64'd0);
      check("rst_mem_addr", {54'd0, mem_addr}, 64'd0);
      check("rst_mem_wd",   {32'd0, mem_wd},   64'd0);
      check("rst_wc",       {53'd0, word_count}, 64'd0);
      check("rst_in_ready", {63'd0, in_ready}, 64'd0);

      // Basic 4-word load
      base = wr_n;
      pulse_start();
      check("basic_busy",  {63'd0, busy},     64'd1);
      check("basic_ready", {63'd0, in_ready}, 64'd1);
      for (int i = 0; i < 4; i++) beat(prog[i], (i == 3));
      check("basic_commit_we",   {63'd0, mem_we},   64'd1);
      check("basic_commit_addr", {54'd0, mem_addr}, 64'd3);
      check("basic_commit_crst", {63'd0, cpu_rst},  64'd1);
      step();
      check("basic_done",  {63'd0, done},       64'd1);
      check("basic_crst",  {63'd0, cpu_rst},    64'd0);
      check("basic_busy0", {63'd0, busy},       64'd0);
      check("basic_wc",    {53'd0, word_count}, 64'd4);
      check("basic_nwr",   64'(wr_n - base),    64'd4);
      for (int i = 0; i < 4; i++) begin
         check("basic_addr", {54'd0, log_addr[base+i]}, 64'(i));
         check("basic_data", {32'd0, log_data[base+i]}, {32'd0, prog[i]});
      end

      // Reload from DONE with a 2-word program
      base = wr_n;
      pulse_start();
      check("reload_crst", {63'd0, cpu_rst},    64'd1);
      check("reload_wc0",  {53'd0, word_count}, 64'd0);
      beat(32'h1111_0001, 1'b0);
      beat(32'h1111_0002, 1'b1);
      step();
      check("reload_done", {63'd0, done},    64'd1);
      check("reload_nwr",  64'(wr_n - base), 64'd2);
      check("reload_a0",   {54'd0, log_addr[base]},   64'd0);
      check("reload_a1",   {54'd0, log_addr[base+1]}, 64'd1);
      check("reload_d1",   {32'd0, log_data[base+1]}, 64'h1111_0002);

      // Backpressure: valid pattern 1,0,0,1,0,1, last on the third beat
      base = wr_n;
      pulse_start();
      beat(32'hA000_0000, 1'b0);
      step(); step();
      beat(32'hA000_0001, 1'b0);
      step();
      beat(32'hA000_0002, 1'b1);
      step(); step();
      check("bp_nwr",  64'(wr_n - base),    64'd3);
      check("bp_done", {63'd0, done},       64'd1);
      check("bp_wc",   {53'd0, word_count}, 64'd3);
      for (int i = 0; i < 3; i++) begin
         check("bp_addr", {54'd0, log_addr[base+i]}, 64'(i));
         check("bp_data", {32'd0, log_data[base+i]}, {32'd0, 32'hA000_0000 + 32'(i)});
      end

      // Overflow: 1025 non-last beats, valid held high throughout
      base = wr_n;
      pulse_start();
      in_valid = 1'b1;
      in_last  = 1'b0;
      for (int i = 0; i < 1025; i++) begin
         in_data = 32'hC000_0000 | 32'(i);
         step();
      end
      in_valid = 1'b0;
      step(); step();
      check("ovf_nwr",   64'(wr_n - base),    64'd1024);
      check("ovf_flag",  {63'd0, overflow},   64'd1);
      check("ovf_ready", {63'd0, in_ready},   64'd0);
      check("ovf_crst",  {63'd0, cpu_rst},    64'd1);
      check("ovf_done",  {63'd0, done},       64'd0);
      check("ovf_wc",    {53'd0, word_count}, 64'd1024);
      bad = 0;
      for (int i = 0; i < 1024; i++) begin
         if (log_addr[base+i] !== ADDR_W'(i)) bad = bad + 1;
         if (log_data[base+i] !== (32'hC000_0000 | 32'(i))) bad = bad + 1;
      end
      check("ovf_seq", 64'(bad), 64'd0);

      // Exact fit: 1024 beats, last on the 1024th (start from ERROR)
      base = wr_n;
      pulse_start();
      check("fit_ovf_clr", {63'd0, overflow}, 64'd0);
      for (int i = 0; i < 1024; i++) beat(32'hD000_0000 | 32'(i), (i == 1023));
      step();
      check("fit_done", {63'd0, done},       64'd1);
      check("fit_ovf",  {63'd0, overflow},   64'd0);
      check("fit_wc",   {53'd0, word_count}, 64'd1024);
      check("fit_crst", {63'd0, cpu_rst},    64'd0);
      check("fit_nwr",  64'(wr_n - base),    64'd1024);
      check("fit_last", {32'd0, log_data[base+1023]}, 64'hD000_03FF);

      // Reset mid-load: 2 of 5 beats, third beat presented in the reset cycle
      base = wr_n;
      pulse_start();
      beat(32'hE000_0000, 1'b0);
      beat(32'hE000_0001, 1'b0);
      rst      = 1'b1;
      in_valid = 1'b1;
      in_data  = 32'hE000_0002;
      step();
      rst = 1'b0;
      in_data = 32'hE000_0003;
      step();
      in_data = 32'hE000_0004;
      in_last = 1'b1;
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      step(); step();
      check("mrst_nwr",   64'(wr_n - base),    64'd2);
      check("mrst_crst",  {63'd0, cpu_rst},    64'd1);
      check("mrst_wc",    {53'd0, word_count}, 64'd0);
      check("mrst_busy",  {63'd0, busy},       64'd0);
      check("mrst_ready", {63'd0, in_ready},   64'd0);
      check("mrst_we",    {63'd0, mem_we},     64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end

endmodule : tb_imem_loader
